// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle control unit and the datapath operand mux.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_ADDI  = 3'b010;
  localparam logic [2:0] OP_LOAD  = 3'b011;
  localparam logic [2:0] OP_STORE = 3'b100;
  localparam logic [2:0] OP_BEQZ  = 3'b101;
  localparam logic [2:0] OP_SUB   = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  localparam logic [1:0] SEL_B = 2'b00;
  localparam logic [1:0] SEL_C = 2'b01;
  localparam logic [1:0] SEL_D = 2'b10;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;

  localparam int WAIT_W = 4;

endpackage

// File: rtl/mc_wait_counter.sv
// Memory-latency down-counter; reloads on every state change, last_o marks the final wait cycle.
module mc_wait_counter
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic last_o
);

  localparam logic [WAIT_W-1:0] RELOAD = WAIT_W'(MEM_LAT - 1);

  logic [WAIT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = RELOAD;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == '0);

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle control FSM for the 8-bit RTN datapath: sequences fetch/decode/exec/mem/wb.
//
// state  | meaning
// IDLE   | waiting for start
// FETCH  | instruction read, MEM_LAT cycles; IR load + PC increment on last cycle
// DECODE | opcode captured into op_q, dispatch
// EXEC   | ALU operation or BEQZ branch decision
// MEM    | LOAD read / STORE write, MEM_LAT cycles
// WB     | accumulator write-back
// HALT   | stopped until reset
module mc_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int OPW     = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  output logic [1:0]     mux_sel,
  output logic [1:0]     alu_op,
  output logic           mem_rd,
  output logic           mem_wr,
  output logic           ir_ld,
  output logic           pc_inc,
  output logic           pc_ld,
  output logic           acc_ld,
  output logic           busy,
  output logic           halted,
  output logic           retire,
  output logic [7:0]     instr_cnt,
  output logic [2:0]     state
);

  state_e         state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  logic           retire_q, retire_d;
  logic [7:0]     instr_cnt_q, instr_cnt_d;
  logic           wait_last;
  logic [2:0]     op_c, in_c;
  logic [1:0]     op_sel, op_alu;

  assign op_c = 3'(op_q);
  assign in_c = 3'(opcode);

  mc_wait_counter #(
    .MEM_LAT (MEM_LAT)
  ) u_wait (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (state_d != state_q),
    .en_i   ((state_q == ST_FETCH) || (state_q == ST_MEM)),
    .last_o (wait_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      retire_q    <= 1'b0;
      instr_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      retire_q    <= retire_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  // retire_d marks the cycle that completes an instruction; the visible pulse is
  // registered so it never depends on the unregistered opcode seen in DECODE.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    retire_d = 1'b0;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_FETCH;
      ST_FETCH:  if (wait_last) state_d = ST_DECODE;
      ST_DECODE: begin
        op_d = opcode;
        case (in_c)
          OP_NOP:            begin state_d = ST_FETCH; retire_d = 1'b1; end
          OP_HALT:           begin state_d = ST_HALT;  retire_d = 1'b1; end
          OP_LOAD, OP_STORE: state_d = ST_MEM;
          default:           state_d = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        if (op_c == OP_BEQZ) begin
          state_d  = ST_FETCH;
          retire_d = 1'b1;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        if (wait_last) begin
          if (op_c == OP_LOAD) begin
            state_d = ST_WB;
          end else begin
            state_d  = ST_FETCH;
            retire_d = 1'b1;
          end
        end
      end
      ST_WB:   begin state_d = ST_FETCH; retire_d = 1'b1; end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
    instr_cnt_d = instr_cnt_q + {7'd0, retire_d};
  end

  always_comb begin
    op_sel = SEL_B;
    op_alu = ALU_PASS;
    case (op_c)
      OP_ADD:  begin op_sel = SEL_B; op_alu = ALU_ADD; end
      OP_SUB:  begin op_sel = SEL_B; op_alu = ALU_SUB; end
      OP_ADDI: begin op_sel = SEL_C; op_alu = ALU_ADD; end
      OP_BEQZ: op_sel = SEL_C;
      OP_LOAD: op_sel = SEL_D;
      default: ;
    endcase
  end

  always_comb begin
    mux_sel = SEL_B;
    alu_op  = ALU_PASS;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    ir_ld   = 1'b0;
    pc_inc  = 1'b0;
    pc_ld   = 1'b0;
    acc_ld  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_rd = 1'b1;
        ir_ld  = wait_last;
        pc_inc = wait_last;
      end
      ST_EXEC: begin
        mux_sel = op_sel;
        alu_op  = op_alu;
        pc_ld   = (op_c == OP_BEQZ) && zero;
      end
      ST_MEM: begin
        mux_sel = op_sel;
        mem_rd  = (op_c == OP_LOAD);
        mem_wr  = (op_c != OP_LOAD);
      end
      ST_WB: begin
        mux_sel = op_sel;
        alu_op  = op_alu;
        acc_ld  = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy      = (state_q != ST_IDLE) && (state_q != ST_HALT);
  assign halted    = (state_q == ST_HALT);
  assign retire    = retire_q;
  assign instr_cnt = instr_cnt_q;
  assign state     = state_q;

endmodule
